// File: rtl/alu_issue_ctrl.sv
// Issue controller for the add/multiply ALU: decodes one instruction at a time, drives the ALU
// operand/phase/PC inputs and writes the returned result back into a small register file.
module alu_issue_ctrl #(
  parameter int          RF_DEPTH = 8,
  parameter logic [31:0] PC_START = 32'd1,
  parameter logic [31:0] FIRE_CNT = 32'd2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  input  logic        flush,
  input  logic        rf_we,
  input  logic [2:0]  rf_waddr,
  input  logic [31:0] rf_wdata,
  input  logic [2:0]  rf_raddr,
  output logic [31:0] rf_rdata,
  output logic [2:0]  func,
  output logic [31:0] data_as,
  output logic [31:0] data_bs,
  output logic [31:0] ins_delay,
  output logic [31:0] IF_pcss,
  input  logic [31:0] result,
  input  logic        arith_flag,
  output logic        wb_valid,
  output logic [2:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        illegal_op
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2,
    ILL  = 2'd3
  } state_t;

  state_t      state_r;
  logic [31:0] rf_r [RF_DEPTH];
  logic [31:0] pc_r;
  logic [31:0] delay_r;
  logic [31:0] op_a_r;
  logic [31:0] op_b_r;
  logic [2:0]  func_r;
  logic [2:0]  rd_r;
  logic [1:0]  phase_r;
  logic        wb_valid_r;
  logic [2:0]  wb_rd_r;
  logic        ill_r;

  logic [2:0]  rs1_s;
  logic [2:0]  rs2_s;
  logic [31:0] op_a_s;
  logic [31:0] op_b_s;
  logic        unused_s;

  // PC never returns to zero on its own: zero is reserved as the ALU clear command.
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return (pc == 32'hFFFF_FFFF) ? PC_START : pc + 32'd1;
  endfunction

  function automatic logic func_legal(input logic [2:0] f);
    return (f == 3'b001) || (f == 3'b010);
  endfunction

  assign rs1_s       = instr[25:23];
  assign rs2_s       = instr[22:20];
  assign instr_ready = (state_r == IDLE) && (pc_r != 32'd0);
  assign rf_rdata    = rf_r[rf_raddr];
  assign func        = func_r;
  assign data_as     = op_a_r;
  assign data_bs     = op_b_r;
  assign ins_delay   = delay_r;
  assign IF_pcss     = pc_r;
  assign wb_valid    = wb_valid_r;
  assign wb_rd       = wb_rd_r;
  assign illegal_op  = ill_r;
  // The ALU only presents its result during the WB cycle, so the writeback data is passed through.
  assign wb_data     = wb_valid_r ? result : 32'd0;
  assign unused_s    = ^{instr[19:0], arith_flag};

  // Operand read with bypass of a preload written in the same (accept) cycle.
  always_comb begin
    op_a_s = rf_r[rs1_s];
    op_b_s = rf_r[rs2_s];
    if (rf_we && (rf_waddr == rs1_s)) begin
      op_a_s = rf_wdata;
    end else begin
      op_a_s = rf_r[rs1_s];
    end
    if (rf_we && (rf_waddr == rs2_s)) begin
      op_b_s = rf_wdata;
    end else begin
      op_b_s = rf_r[rs2_s];
    end
  end

  // Issue FSM, register file and all ALU-facing registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r    <= IDLE;
      pc_r       <= 32'd0;
      delay_r    <= 32'd0;
      op_a_r     <= 32'd0;
      op_b_r     <= 32'd0;
      func_r     <= 3'd0;
      rd_r       <= 3'd0;
      phase_r    <= 2'd0;
      wb_valid_r <= 1'b0;
      wb_rd_r    <= 3'd0;
      ill_r      <= 1'b0;
      for (int i = 0; i < RF_DEPTH; i++) begin
        rf_r[i] <= 32'd0;
      end
    end else if (flush) begin
      state_r    <= IDLE;
      pc_r       <= 32'd0;
      delay_r    <= 32'd0;
      phase_r    <= 2'd0;
      wb_valid_r <= 1'b0;
      ill_r      <= 1'b0;
    end else begin
      wb_valid_r <= 1'b0;
      ill_r      <= 1'b0;
      case (state_r)
        IDLE: begin
          delay_r <= 32'd0;
          if (rf_we) begin
            rf_r[rf_waddr] <= rf_wdata;
          end
          if (pc_r == 32'd0) begin
            pc_r <= PC_START;
          end else if (instr_valid) begin
            if (func_legal(instr[31:29])) begin
              state_r <= EXEC;
              func_r  <= instr[31:29];
              rd_r    <= instr[28:26];
              op_a_r  <= op_a_s;
              op_b_r  <= op_b_s;
              phase_r <= 2'd0;
            end else begin
              state_r <= ILL;
              ill_r   <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (phase_r == 2'd0) begin
            phase_r <= 2'd1;
            delay_r <= 32'd1;
          end else if (phase_r == 2'd1) begin
            phase_r <= 2'd2;
            delay_r <= FIRE_CNT;
          end else begin
            state_r    <= WB;
            wb_valid_r <= 1'b1;
            wb_rd_r    <= rd_r;
          end
        end
        WB: begin
          rf_r[rd_r] <= result;
          pc_r       <= pc_next(pc_r);
          delay_r    <= 32'd0;
          state_r    <= IDLE;
        end
        ILL: begin
          pc_r    <= pc_next(pc_r);
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: behavioural ALU, writeback scoreboard, vector table
// plus directed flush / reset / PC-wrap sequences.
module tb_alu_issue_ctrl;

  localparam logic [31:0] PC_START = 32'd1;

  logic        clk = 1'b0;
  logic        nrst;
  logic        instr_valid, instr_valid2;
  logic [31:0] instr;
  logic        flush;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [2:0]  rf_raddr;

  logic        instr_ready, instr_ready2;
  logic [31:0] rf_rdata, rf_rdata2;
  logic [2:0]  func, func2;
  logic [31:0] data_as, data_bs, ins_delay, if_pcss;
  logic [31:0] data_as2, data_bs2, ins_delay2, if_pcss2;
  logic        wb_valid, wb_valid2, illegal_op, illegal_op2;
  logic [2:0]  wb_rd, wb_rd2;
  logic [31:0] wb_data, wb_data2;
  logic [31:0] alu_result;
  logic        alu_flag;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [2:0]  rd;
    logic [31:0] data;
    int          acc;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  typedef struct {
    logic        pa_en;
    logic [2:0]  pa_addr;
    logic [31:0] pa_data;
    logic        pb_en;
    logic        pb_same;
    logic [2:0]  pb_addr;
    logic [31:0] pb_data;
    logic [2:0]  f, rd, rs1, rs2;
    logic [31:0] exp;
    logic        poke;
  } vec_t;
  vec_t vt[10];

  logic [31:0] rf_m [8];
  logic [31:0] pc_m;

  alu_issue_ctrl #(.RF_DEPTH(8), .PC_START(PC_START), .FIRE_CNT(32'd2)) dut (
    .clk(clk), .nrst(nrst), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .flush(flush), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .func(func), .data_as(data_as), .data_bs(data_bs),
    .ins_delay(ins_delay), .IF_pcss(if_pcss), .result(alu_result), .arith_flag(alu_flag),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .illegal_op(illegal_op)
  );

  // Second instance starts near the top of the PC range to exercise the wrap.
  alu_issue_ctrl #(.RF_DEPTH(8), .PC_START(32'hFFFF_FFFE), .FIRE_CNT(32'd2)) dut2 (
    .clk(clk), .nrst(nrst), .instr_valid(instr_valid2), .instr(instr), .instr_ready(instr_ready2),
    .flush(flush), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata2), .func(func2), .data_as(data_as2), .data_bs(data_bs2),
    .ins_delay(ins_delay2), .IF_pcss(if_pcss2), .result(32'd0), .arith_flag(1'b0),
    .wb_valid(wb_valid2), .wb_rd(wb_rd2), .wb_data(wb_data2), .illegal_op(illegal_op2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: clears on PC 0, samples operands when the phase counter reaches 2.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      alu_result <= 32'd0;
      alu_flag   <= 1'b0;
    end else if (if_pcss == 32'd0) begin
      alu_result <= 32'd0;
      alu_flag   <= 1'b0;
    end else if (ins_delay == 32'd2) begin
      if (func == 3'b001) begin
        alu_result <= data_as + data_bs;
        alu_flag   <= 1'b1;
      end else if (func == 3'b010) begin
        alu_result <= data_as * data_bs;
        alu_flag   <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pc_inc(input logic [31:0] p);
    return (p == 32'hFFFF_FFFF) ? PC_START : p + 32'd1;
  endfunction

  // Writeback scoreboard: every wb_valid pulse must match the oldest expected retirement.
  always @(negedge clk) begin
    if (nrst && wb_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_wb", {29'd0, wb_rd}, 32'hDEAD_BEEF);
      end else begin
        e = sb.pop_front();
        chk("wb_rd", {29'd0, wb_rd}, {29'd0, e.rd});
        chk("wb_data", wb_data, e.data);
        chk("wb_latency", cyc - e.acc, 32'd4);
      end
    end
  end

  task automatic preload(input logic [2:0] a, input logic [31:0] d);
    rf_we = 1'b1; rf_waddr = a; rf_wdata = d;
    @(negedge clk);
    rf_we = 1'b0;
    rf_m[a] = d;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'd0, instr_ready}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    logic legal;
    legal = (v.f == 3'b001) || (v.f == 3'b010);
    if (v.pa_en) preload(v.pa_addr, v.pa_data);
    if (v.pb_en && !v.pb_same) preload(v.pb_addr, v.pb_data);
    wait_ready();
    instr_valid = 1'b1;
    instr = {v.f, v.rd, v.rs1, v.rs2, 20'h0};
    if (v.pb_en && v.pb_same) begin
      rf_we = 1'b1; rf_waddr = v.pb_addr; rf_wdata = v.pb_data;
      rf_m[v.pb_addr] = v.pb_data;
    end
    if (legal) sb.push_back('{rd: v.rd, data: v.exp, acc: cyc});
    @(negedge clk);
    instr_valid = 1'b0;
    rf_we = 1'b0;
    if (legal) begin
      chk("ins_delay_0", ins_delay, 32'd0);
      chk("func", {29'd0, func}, {29'd0, v.f});
      if (v.poke) begin
        rf_we = 1'b1; rf_waddr = 3'd5; rf_wdata = 32'd999;
      end
      @(negedge clk);
      rf_we = 1'b0;
      chk("ins_delay_1", ins_delay, 32'd1);
      @(negedge clk);
      chk("ins_delay_2", ins_delay, 32'd2);
      chk("data_as", data_as, rf_m[v.rs1]);
      chk("data_bs", data_bs, rf_m[v.rs2]);
      rf_m[v.rd] = v.exp;
      @(negedge clk);
      @(negedge clk);
      pc_m = pc_inc(pc_m);
      chk("pc_after_op", if_pcss, pc_m);
      chk("ins_delay_idle", ins_delay, 32'd0);
      chk("arith_flag", {31'd0, alu_flag}, 32'd1);
    end else begin
      chk("illegal_op_hi", {31'd0, illegal_op}, 32'd1);
      @(negedge clk);
      chk("illegal_op_lo", {31'd0, illegal_op}, 32'd0);
      pc_m = pc_inc(pc_m);
      chk("pc_after_ill", if_pcss, pc_m);
    end
    rf_raddr = v.rd; #1;
    chk("rf_rd", rf_rdata, rf_m[v.rd]);
    rf_raddr = 3'd5; #1;
    chk("rf_r5", rf_rdata, rf_m[5]);
  endtask

  // Start an add and stop after the first operand phase (ins_delay == 1).
  task automatic start_and_hold();
    wait_ready();
    instr_valid = 1'b1;
    instr = {3'b001, 3'd4, 3'd1, 3'd2, 20'h0};
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("mid_exec_delay", ins_delay, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //         pa_en addr data          pb_en same addr data          f       rd    rs1   rs2   exp            poke
    vt[0] = '{1'b1, 3'd1, 32'd5,        1'b1, 1'b0, 3'd2, 32'd7,       3'b001, 3'd3, 3'd1, 3'd2, 32'd12,       1'b0};
    vt[1] = '{1'b1, 3'd4, 32'h0001_0000, 1'b1, 1'b0, 3'd5, 32'h0001_0000, 3'b010, 3'd6, 3'd4, 3'd5, 32'd0,      1'b0};
    vt[2] = '{1'b1, 3'd4, 32'd3,        1'b1, 1'b0, 3'd5, 32'd9,       3'b010, 3'd6, 3'd4, 3'd5, 32'd27,       1'b1};
    vt[3] = '{1'b1, 3'd1, 32'hFFFF_FFFF, 1'b1, 1'b0, 3'd2, 32'd1,      3'b001, 3'd7, 3'd1, 3'd2, 32'd0,        1'b0};
    vt[4] = '{1'b1, 3'd0, 32'd6,        1'b0, 1'b0, 3'd0, 32'd0,       3'b010, 3'd0, 3'd0, 3'd0, 32'd36,       1'b0};
    vt[5] = '{1'b0, 3'd0, 32'd0,        1'b0, 1'b0, 3'd0, 32'd0,       3'b001, 3'd3, 3'd3, 3'd3, 32'd24,       1'b0};
    vt[6] = '{1'b1, 3'd1, 32'd50,       1'b1, 1'b1, 3'd1, 32'd40,      3'b001, 3'd2, 3'd1, 3'd1, 32'd80,       1'b0};
    vt[7] = '{1'b0, 3'd0, 32'd0,        1'b0, 1'b0, 3'd0, 32'd0,       3'b111, 3'd3, 3'd1, 3'd2, 32'd0,        1'b0};
    vt[8] = '{1'b0, 3'd0, 32'd0,        1'b0, 1'b0, 3'd0, 32'd0,       3'b000, 3'd2, 3'd1, 3'd1, 32'd0,        1'b0};
    vt[9] = '{1'b0, 3'd0, 32'd0,        1'b0, 1'b0, 3'd0, 32'd0,       3'b010, 3'd1, 3'd2, 3'd6, 32'd2160,     1'b0};

    nrst = 1'b0; instr_valid = 1'b0; instr_valid2 = 1'b0; instr = 32'd0; flush = 1'b0;
    rf_we = 1'b0; rf_waddr = 3'd0; rf_wdata = 32'd0; rf_raddr = 3'd0;
    for (int i = 0; i < 8; i++) rf_m[i] = 32'd0;
    pc_m = PC_START;

    repeat (2) @(negedge clk);
    chk("rst_pc", if_pcss, 32'd0);
    chk("rst_delay", ins_delay, 32'd0);
    chk("rst_func", {29'd0, func}, 32'd0);
    chk("rst_data_as", data_as, 32'd0);
    chk("rst_data_bs", data_bs, 32'd0);
    chk("rst_wb", {28'd0, wb_valid, wb_rd}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_ill", {31'd0, illegal_op}, 32'd0);
    chk("rst_ready", {31'd0, instr_ready}, 32'd0);
    chk("rst_rf", rf_rdata, 32'd0);
    nrst = 1'b1;
    #1;
    chk("rel_ready", {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    chk("pc_start", if_pcss, PC_START);
    chk("ready_up", {31'd0, instr_ready}, 32'd1);
    chk("pc2_start", if_pcss2, 32'hFFFF_FFFE);

    // PC wrap on the second instance: FFFFFFFE -> FFFFFFFF -> PC_START (FFFFFFFE), never 0.
    instr = {3'b001, 3'd1, 3'd0, 3'd0, 20'h0};
    instr_valid2 = 1'b1;
    @(negedge clk);
    instr_valid2 = 1'b0;
    repeat (4) @(negedge clk);
    chk("pc2_inc", if_pcss2, 32'hFFFF_FFFF);
    instr_valid2 = 1'b1;
    @(negedge clk);
    instr_valid2 = 1'b0;
    repeat (4) @(negedge clk);
    chk("pc2_wrap", if_pcss2, 32'hFFFF_FFFE);

    for (int i = 0; i < 10; i++) run_vec(vt[i]);

    // Flush mid-EXEC: PC drops to 0 for one cycle, op discarded.
    start_and_hold();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_pc0", if_pcss, 32'd0);
    chk("flush_delay", ins_delay, 32'd0);
    chk("flush_ready", {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    chk("flush_pc_restart", if_pcss, PC_START);
    pc_m = PC_START;
    repeat (5) @(negedge clk);
    rf_raddr = 3'd4; #1;
    chk("flush_no_write", rf_rdata, rf_m[4]);

    // Flush and instr_valid together: instruction not accepted.
    instr_valid = 1'b1;
    instr = {3'b001, 3'd4, 3'd1, 3'd2, 20'h0};
    flush = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    flush = 1'b0;
    chk("flushv_pc0", if_pcss, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("flushv_not_taken", ins_delay, 32'd0);
    chk("flushv_pc", if_pcss, PC_START);
    repeat (4) @(negedge clk);

    // Asynchronous reset mid-EXEC.
    start_and_hold();
    #2 nrst = 1'b0;
    #1;
    chk("arst_pc", if_pcss, 32'd0);
    chk("arst_delay", ins_delay, 32'd0);
    chk("arst_data_as", data_as, 32'd0);
    chk("arst_func", {29'd0, func}, 32'd0);
    chk("arst_ready", {31'd0, instr_ready}, 32'd0);
    for (int i = 0; i < 8; i++) rf_m[i] = 32'd0;
    pc_m = PC_START;
    @(negedge clk);
    nrst = 1'b1;
    #1;
    chk("arst_ready_hold", {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    chk("arst_pc_start", if_pcss, PC_START);
    repeat (5) @(negedge clk);
    chk("arst_no_wb_pending", sb.size(), 32'd0);

    run_vec(vt[0]);
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
